// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator: STEP bits per clock, registered g/e/l
// flags with a one-cycle done pulse, signed or unsigned per operation.

module serial_magnitude_comparator_chk (
  input logic clk,
  input logic rst_n,
  input logic g,
  input logic e,
  input logic l,
  input logic busy,
  input logic done
);

  // Flag/done invariants: at most one flag ever, exactly one on completion, single-cycle done
  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0({g, e, l}));
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) done |-> $onehot({g, e, l}));
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule

module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             g,
  output logic             e,
  output logic             l,
  output logic             busy,
  output logic             done
);

  localparam int CHUNKS = WIDTH / STEP;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CHUNKS - 1);
  // Flipping the sign bit maps two's-complement order onto unsigned order
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sa_r, sb_r, sa_s, sb_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             sticky_vld_r, sticky_gt_r, sticky_vld_s, sticky_gt_s;
  logic             g_r, e_r, l_r, done_r;
  logic             g_s, e_s, l_s, done_s;
  logic [STEP-1:0]  ca_s, cb_s;
  logic             chunk_gt_s, chunk_lt_s;

  assign ca_s       = sa_r[WIDTH-1 -: STEP];
  assign cb_s       = sb_r[WIDTH-1 -: STEP];
  assign chunk_gt_s = (ca_s > cb_s);
  assign chunk_lt_s = (ca_s < cb_s);

  // Next-state, datapath and flag logic
  always_comb begin
    state_s      = state_r;
    sa_s         = sa_r;
    sb_s         = sb_r;
    cnt_s        = cnt_r;
    sticky_vld_s = sticky_vld_r;
    sticky_gt_s  = sticky_gt_r;
    g_s          = g_r;
    e_s          = e_r;
    l_s          = l_r;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !clr) begin
          state_s      = RUN;
          sa_s         = sgn ? (a ^ MSB_MASK) : a;
          sb_s         = sgn ? (b ^ MSB_MASK) : b;
          cnt_s        = CNT_LOAD;
          sticky_vld_s = 1'b0;
          sticky_gt_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (clr) begin
          state_s = IDLE;
        end else if (EARLY_EXIT && (chunk_gt_s || chunk_lt_s)) begin
          state_s = IDLE;
          done_s  = 1'b1;
          g_s     = chunk_gt_s;
          e_s     = 1'b0;
          l_s     = chunk_lt_s;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_s = IDLE;
          done_s  = 1'b1;
          // An earlier differing chunk outranks the final one
          if (sticky_vld_r) begin
            g_s = sticky_gt_r;
            e_s = 1'b0;
            l_s = !sticky_gt_r;
          end else begin
            g_s = chunk_gt_s;
            e_s = !(chunk_gt_s || chunk_lt_s);
            l_s = chunk_lt_s;
          end
        end else begin
          sa_s  = sa_r << STEP;
          sb_s  = sb_r << STEP;
          cnt_s = cnt_r - CW'(1'b1);
          if (!sticky_vld_r && (chunk_gt_s || chunk_lt_s)) begin
            sticky_vld_s = 1'b1;
            sticky_gt_s  = chunk_gt_s;
          end else begin
            sticky_vld_s = sticky_vld_r;
            sticky_gt_s  = sticky_gt_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand shifters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sa_r         <= {WIDTH{1'b0}};
      sb_r         <= {WIDTH{1'b0}};
      cnt_r        <= {CW{1'b0}};
      sticky_vld_r <= 1'b0;
      sticky_gt_r  <= 1'b0;
      g_r          <= 1'b0;
      e_r          <= 1'b0;
      l_r          <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      sa_r         <= sa_s;
      sb_r         <= sb_s;
      cnt_r        <= cnt_s;
      sticky_vld_r <= sticky_vld_s;
      sticky_gt_r  <= sticky_gt_s;
      g_r          <= g_s;
      e_r          <= e_s;
      l_r          <= l_s;
      done_r       <= done_s;
    end
  end

  assign g    = g_r;
  assign e    = e_r;
  assign l    = l_r;
  assign done = done_r;
  assign busy = (state_r == RUN);

  serial_magnitude_comparator_chk u_chk (
    .clk  (clk),
    .rst_n(rst_n),
    .g    (g_r),
    .e    (e_r),
    .l    (l_r),
    .busy (busy),
    .done (done_r)
  );

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: six comparator configurations against an arithmetic reference
// model, with directed literal checks and randomized back-to-back/abort traffic.

module tb_serial_magnitude_comparator;

  localparam int NC = 6;
  localparam logic [2:0] FG = 3'b100;
  localparam logic [2:0] FE = 3'b010;
  localparam logic [2:0] FL = 3'b001;

  function automatic int cfg_w(int c);
    case (c)
      0, 1, 2: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_s(int c);
    case (c)
      0, 5:    return 1;
      3:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_ee(int c);
    case (c)
      2, 4:    return 0;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v[NC], start_v[NC], sgn_v[NC], clr_v[NC];
  logic [15:0] a_v[NC], b_v[NC];
  logic        g_v[NC], e_v[NC], l_v[NC], busy_v[NC], done_v[NC];

  for (genvar c = 0; c < NC; c++) begin : g_dut
    localparam int W = cfg_w(c);
    serial_magnitude_comparator #(
      .WIDTH     (W),
      .STEP      (cfg_s(c)),
      .EARLY_EXIT(cfg_ee(c) != 0)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_v[c]),
      .start(start_v[c]),
      .sgn  (sgn_v[c]),
      .clr  (clr_v[c]),
      .a    (a_v[c][W-1:0]),
      .b    (b_v[c][W-1:0]),
      .g    (g_v[c]),
      .e    (e_v[c]),
      .l    (l_v[c]),
      .busy (busy_v[c]),
      .done (done_v[c])
    );
  end

  // Reference: order from plain integer arithmetic, latency from the chunk rule
  function automatic logic [2:0] verdict(int w, logic sg, logic [15:0] x, logic [15:0] y);
    int xv, yv;
    xv = int'(x) & ((1 << w) - 1);
    yv = int'(y) & ((1 << w) - 1);
    if (sg && xv >= (1 << (w - 1))) xv -= (1 << w);
    if (sg && yv >= (1 << (w - 1))) yv -= (1 << w);
    if (xv > yv) return FG;
    else if (xv == yv) return FE;
    else return FL;
  endfunction

  function automatic int exp_lat(int w, int s, int ee, logic [15:0] x, logic [15:0] y);
    int ch, m, sh, xv, yv;
    ch = w / s;
    m  = (1 << s) - 1;
    xv = int'(x);
    yv = int'(y);
    if (ee == 0) return ch;
    for (int i = 0; i < ch; i++) begin
      sh = w - (i + 1) * s;
      if (((xv >> sh) & m) != ((yv >> sh) & m)) return i + 1;
    end
    return ch;
  endfunction

  bit         m_busy[NC], m_done[NC];
  int         m_rem[NC], ops_acc[NC];
  logic [2:0] m_flags[NC], m_pend[NC];
  int         vec_cnt = 0;
  int         miss_cnt = 0;

  logic [7:0] dir_a [7] = '{8'hA5, 8'h80, 8'h80, 8'h3C, 8'h4C, 8'h12, 8'hFF};
  logic [7:0] dir_b [7] = '{8'hA5, 8'h7F, 8'h7F, 8'h3D, 8'h3D, 8'h13, 8'h00};
  logic       dir_sg[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0] dir_f [7] = '{FE, FG, FL, FL, FG, FL, FL};
  int lat_tab[7][NC] = '{'{8, 2, 2, 8, 4, 16},
                         '{1, 1, 2, 1, 4, 1},
                         '{1, 1, 2, 1, 4, 1},
                         '{8, 2, 2, 4, 4, 8},
                         '{2, 1, 2, 1, 4, 2},
                         '{8, 2, 2, 4, 4, 8},
                         '{1, 1, 2, 1, 4, 1}};

  task automatic model_reset(int c);
    m_busy[c]  = 1'b0;
    m_done[c]  = 1'b0;
    m_rem[c]   = 0;
    m_flags[c] = 3'b000;
    m_pend[c]  = 3'b000;
  endtask

  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      if (!rst_v[c]) begin
        model_reset(c);
      end else begin
        m_done[c] = 1'b0;
        if (m_busy[c]) begin
          if (clr_v[c]) begin
            m_busy[c] = 1'b0;
          end else begin
            m_rem[c]--;
            if (m_rem[c] == 0) begin
              m_busy[c]  = 1'b0;
              m_done[c]  = 1'b1;
              m_flags[c] = m_pend[c];
            end
          end
        end else if (start_v[c] && !clr_v[c]) begin
          m_busy[c] = 1'b1;
          m_rem[c]  = exp_lat(cfg_w(c), cfg_s(c), cfg_ee(c), a_v[c], b_v[c]);
          m_pend[c] = verdict(cfg_w(c), sgn_v[c], a_v[c], b_v[c]);
          ops_acc[c]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NC; c++) begin
      vec_cnt++;
      if (busy_v[c] !== m_busy[c] || done_v[c] !== m_done[c] ||
          {g_v[c], e_v[c], l_v[c]} !== m_flags[c]) begin
        miss_cnt++;
        $display("FAIL model_check cfg%0d t=%0t busy,done,gel got %b,%b,%b%b%b expected %b,%b,%03b",
                 c, $time, busy_v[c], done_v[c], g_v[c], e_v[c], l_v[c],
                 m_busy[c], m_done[c], m_flags[c]);
      end
    end
  endtask

  task automatic check_lit(string name, int c, int got, int want);
    vec_cnt++;
    if (got != want) begin
      miss_cnt++;
      $display("FAIL %s cfg%0d t=%0t got %0d expected %0d", name, c, $time, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [15:0] place(int c, logic [7:0] v);
    return (cfg_w(c) == 16) ? {v, 8'h00} : {8'h00, v};
  endfunction

  // One directed op from the table; poke issues a stray start while busy
  task automatic run_op(int c, int d, bit poke);
    int lat;
    start_v[c] = 1'b1;
    sgn_v[c]   = dir_sg[d];
    a_v[c]     = place(c, dir_a[d]);
    b_v[c]     = place(c, dir_b[d]);
    tick();
    start_v[c] = 1'b0;
    lat = 0;
    for (int j = 1; j <= 40 && lat == 0; j++) begin
      tick();
      if (poke && j == 1) begin
        start_v[c] = 1'b1;
        a_v[c]     = 16'hFFFF;
      end else begin
        start_v[c] = 1'b0;
      end
      if (done_v[c]) lat = j;
    end
    check_lit("dir_latency", c, lat, lat_tab[d][c]);
    check_lit("dir_flags", c, int'({g_v[c], e_v[c], l_v[c]}), int'(dir_f[d]));
  endtask

  initial begin
    int   w, k;
    int   xv, yv;
    bit   more;
    for (int c = 0; c < NC; c++) begin
      rst_v[c] = 1'b1; start_v[c] = 1'b0; sgn_v[c] = 1'b0; clr_v[c] = 1'b0;
      a_v[c] = 16'h0000; b_v[c] = 16'h0000; ops_acc[c] = 0;
      model_reset(c);
    end
    #1;
    for (int c = 0; c < NC; c++) rst_v[c] = 1'b0;

    check_lit("pin_verdict_u", 0, int'(verdict(8, 1'b0, 16'h0080, 16'h007F)), int'(FG));
    check_lit("pin_verdict_s", 0, int'(verdict(8, 1'b1, 16'h0080, 16'h007F)), int'(FL));
    check_lit("pin_verdict_s16", 0, int'(verdict(16, 1'b1, 16'h8000, 16'h0001)), int'(FL));
    check_lit("pin_lat_ee", 0, exp_lat(8, 4, 1, 16'h003C, 16'h003D), 2);
    check_lit("pin_lat_noee", 0, exp_lat(8, 4, 0, 16'h004C, 16'h003D), 2);
    check_lit("pin_lat_first", 0, exp_lat(8, 4, 1, 16'h004C, 16'h003D), 1);
    check_lit("pin_lat_equal", 0, exp_lat(8, 1, 1, 16'h00A5, 16'h00A5), 8);

    tick();
    check_lit("reset_gel", 0, int'({g_v[0], e_v[0], l_v[0]}), 0);
    check_lit("reset_busy", 0, int'(busy_v[0]), 0);
    for (int c = 0; c < NC; c++) rst_v[c] = 1'b1;
    tick();

    for (int c = 0; c < NC; c++) begin
      for (int d = 0; d < 5; d++) run_op(c, d, 1'b0);
      // Abort after a g result: no done, flags keep g
      start_v[c] = 1'b1; sgn_v[c] = 1'b0;
      a_v[c] = place(c, 8'hA5); b_v[c] = place(c, 8'hA5);
      tick();
      start_v[c] = 1'b0;
      tick();
      clr_v[c] = 1'b1;
      tick();
      clr_v[c] = 1'b0;
      check_lit("clr_busy", c, int'(busy_v[c]), 0);
      check_lit("clr_done", c, int'(done_v[c]), 0);
      check_lit("clr_flags", c, int'({g_v[c], e_v[c], l_v[c]}), int'(FG));
      run_op(c, 5, 1'b1);
      run_op(c, 6, 1'b0);
      // Asynchronous reset in the middle of an operation
      start_v[c] = 1'b1;
      a_v[c] = place(c, 8'h12); b_v[c] = place(c, 8'h13);
      tick();
      start_v[c] = 1'b0;
      tick();
      #2;
      rst_v[c] = 1'b0;
      model_reset(c);
      #1;
      check_lit("rst_busy", c, int'(busy_v[c]), 0);
      check_lit("rst_done", c, int'(done_v[c]), 0);
      check_lit("rst_flags", c, int'({g_v[c], e_v[c], l_v[c]}), 0);
      tick();
      rst_v[c] = 1'b1;
      tick();
    end

    for (int c = 0; c < NC; c++) ops_acc[c] = 0;
    more = 1'b1;
    for (int cyc = 0; cyc < 20000 && more; cyc++) begin
      for (int c = 0; c < NC; c++) begin
        w  = cfg_w(c);
        k  = $urandom_range(w - 1, 0);
        xv = int'($urandom & 32'hFFFF) & ((1 << w) - 1);
        case ($urandom_range(3, 0))
          0:       yv = xv;
          1:       yv = xv ^ (1 << k);
          2:       yv = int'($urandom & 32'hFFFF);
          default: yv = xv ^ (int'($urandom & 32'hFFFF) & ((1 << k) - 1));
        endcase
        k = $urandom_range(15, 0);
        start_v[c] = (k < 9);
        clr_v[c]   = (k == 15);
        sgn_v[c]   = $urandom_range(1, 0) == 1;
        a_v[c]     = 16'(xv);
        b_v[c]     = 16'(yv & ((1 << w) - 1));
      end
      tick();
      more = 1'b0;
      for (int c = 0; c < NC; c++) if (ops_acc[c] < 340) more = 1'b1;
    end
    for (int c = 0; c < NC; c++) begin
      check_lit("random_ops_done", c, int'(ops_acc[c] >= 340), 1);
      start_v[c] = 1'b0;
      clr_v[c]   = 1'b0;
    end
    for (int i = 0; i < 20; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
